// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer voice path: allocator state encoding,
// default sizing and a constant-foldable clog2 helper.
package synth_pkg;

  localparam int DEF_NUM_KEYS   = 8;
  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_AGE_W      = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STEAL_REL  = 2'd1,
    STEAL_TRIG = 2'd2
  } alloc_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters; reports the oldest voice, lowest index on a tie.
module voice_age_tracker
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W      = DEF_AGE_W,
  parameter int VIDX_W     = (NUM_VOICES > 1) ? clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_VOICES-1:0] voice_active,
  input  logic [NUM_VOICES-1:0] clear,
  output logic [VIDX_W-1:0]     oldest
);

  logic [AGE_W-1:0] age [NUM_VOICES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (clear[v] || !voice_active[v]) begin
          age[v] <= '0;
        end else if (age[v] != '1) begin
          age[v] <= age[v] + 1'b1;
        end
      end
    end
  end

  // Strict comparison keeps the lowest index when ages tie (including saturated ones).
  always_comb begin
    logic [AGE_W-1:0] best_age;
    oldest   = '0;
    best_age = age[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > best_age) begin
        best_age = age[v];
        oldest   = VIDX_W'(v);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: turns debounced key edges into voice trigger/release
// pulses, stealing the oldest voice when all voices are busy.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_KEYS   = DEF_NUM_KEYS,
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int KEY_W      = clog2(NUM_KEYS),
  parameter int AGE_W      = DEF_AGE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         key_level,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_trig,
  output logic [NUM_VOICES-1:0]       voice_rel,
  output logic                        busy
);

  localparam int VIDX_W = (NUM_VOICES > 1) ? clog2(NUM_VOICES) : 1;

  alloc_state_t          state;
  logic [NUM_KEYS-1:0]   key_q;
  logic [NUM_KEYS-1:0]   pending_on;
  logic [NUM_KEYS-1:0]   pending_off;
  logic [NUM_KEYS-1:0]   rise;
  logic [NUM_KEYS-1:0]   fall;
  logic [NUM_KEYS-1:0]   clr_on;
  logic [NUM_KEYS-1:0]   clr_off;
  logic [VIDX_W-1:0]     victim;
  logic [KEY_W-1:0]      steal_key;
  logic [VIDX_W-1:0]     oldest;
  logic [NUM_VOICES-1:0] age_clear;

  logic                  off_found;
  logic [KEY_W-1:0]      off_key;
  logic                  on_found;
  logic [KEY_W-1:0]      on_key;
  logic                  off_hit;
  logic [VIDX_W-1:0]     off_voice;
  logic                  on_dup;
  logic                  free_found;
  logic [VIDX_W-1:0]     free_voice;
  logic                  svc_off;
  logic                  svc_on;

  assign rise = key_level & ~key_q;
  assign fall = ~key_level & key_q;

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .VIDX_W     (VIDX_W)
  ) u_age (
    .clk          (clk),
    .rst_n        (rst_n),
    .voice_active (voice_active),
    .clear        (age_clear),
    .oldest       (oldest)
  );

  always_comb begin
    off_found  = 1'b0;
    off_key    = '0;
    on_found   = 1'b0;
    on_key     = '0;
    off_hit    = 1'b0;
    off_voice  = '0;
    on_dup     = 1'b0;
    free_found = 1'b0;
    free_voice = '0;
    clr_on     = '0;
    clr_off    = '0;
    age_clear  = '0;

    // Descending scans so the lowest matching index is the one left standing.
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pending_off[k]) begin
        off_found = 1'b1;
        off_key   = KEY_W'(k);
      end
      if (pending_on[k]) begin
        on_found = 1'b1;
        on_key   = KEY_W'(k);
      end
    end

    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voice_active[v] && voice_key[v*KEY_W +: KEY_W] == off_key) begin
        off_hit   = 1'b1;
        off_voice = VIDX_W'(v);
      end
      if (voice_active[v] && voice_key[v*KEY_W +: KEY_W] == on_key) on_dup = 1'b1;
      if (!voice_active[v]) begin
        free_found = 1'b1;
        free_voice = VIDX_W'(v);
      end
    end

    svc_off = (state == IDLE) && off_found;
    svc_on  = (state == IDLE) && !off_found && on_found;
    if (svc_off) clr_off[off_key] = 1'b1;
    if (svc_on)  clr_on[on_key]   = 1'b1;

    if (svc_on && !on_dup && free_found) age_clear[free_voice] = 1'b1;
    if (state == STEAL_TRIG)             age_clear[victim]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      key_q        <= '0;
      pending_on   <= '0;
      pending_off  <= '0;
      victim       <= '0;
      steal_key    <= '0;
      voice_active <= '0;
      voice_key    <= '0;
      voice_trig   <= '0;
      voice_rel    <= '0;
    end else begin
      key_q       <= key_level;
      // A release of a press still waiting for service cancels it instead of queueing an off.
      pending_on  <= (pending_on & ~clr_on & ~fall) | rise;
      pending_off <= (pending_off & ~clr_off) | (fall & ~(pending_on & ~clr_on));
      voice_trig  <= '0;
      voice_rel   <= '0;

      case (state)
        IDLE: begin
          if (svc_off) begin
            if (off_hit) begin
              voice_active[off_voice] <= 1'b0;
              voice_rel[off_voice]    <= 1'b1;
            end
          end else if (svc_on && !on_dup) begin
            if (free_found) begin
              voice_key[free_voice*KEY_W +: KEY_W] <= on_key;
              voice_active[free_voice]             <= 1'b1;
              voice_trig[free_voice]               <= 1'b1;
            end else begin
              victim    <= oldest;
              steal_key <= on_key;
              state     <= STEAL_REL;
              busy      <= 1'b1;
            end
          end
        end
        STEAL_REL: begin
          voice_rel[victim]    <= 1'b1;
          voice_active[victim] <= 1'b0;
          state                <= STEAL_TRIG;
        end
        STEAL_TRIG: begin
          voice_key[victim*KEY_W +: KEY_W] <= steal_key;
          voice_active[victim]             <= 1'b1;
          voice_trig[victim]               <= 1'b1;
          state                            <= IDLE;
          busy                             <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random key activity
// checked against a behavioural allocation model.
module tb_voice_allocator;

  localparam int NK = 8;
  localparam int NV = 4;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_level = '0;
  logic [NV-1:0] voice_active;
  logic [NV*KW-1:0] voice_key;
  logic [NV-1:0] voice_trig;
  logic [NV-1:0] voice_rel;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW), .AGE_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_level    (key_level),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .voice_trig   (voice_trig),
    .voice_rel    (voice_rel),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: voices remember the cycle they were triggered; age is derived from it.
  bit m_kq[NK], m_pon[NK], m_poff[NK];
  bit m_act[NV], m_trig[NV], m_rel[NV];
  int m_key[NV], m_tcyc[NV];
  int m_phase, m_vic, m_skey, cyc;

  task automatic model_step(input logic [NK-1:0] kl, input logic rstn);
    int svc_on, svc_off, fv, best, best_age, a;
    bit dup;
    cyc++;
    for (int v = 0; v < NV; v++) begin m_trig[v] = 0; m_rel[v] = 0; end
    if (!rstn) begin
      for (int k = 0; k < NK; k++) begin m_kq[k] = 0; m_pon[k] = 0; m_poff[k] = 0; end
      for (int v = 0; v < NV; v++) begin m_act[v] = 0; m_key[v] = 0; m_tcyc[v] = cyc; end
      m_phase = 0;
      return;
    end
    svc_on = -1; svc_off = -1;
    if (m_phase == 0) begin
      for (int k = NK - 1; k >= 0; k--) if (m_poff[k]) svc_off = k;
      if (svc_off < 0) for (int k = NK - 1; k >= 0; k--) if (m_pon[k]) svc_on = k;
      if (svc_off >= 0) begin
        for (int v = 0; v < NV; v++)
          if (m_act[v] && m_key[v] == svc_off) begin m_act[v] = 0; m_rel[v] = 1; end
      end else if (svc_on >= 0) begin
        dup = 0; fv = -1;
        for (int v = 0; v < NV; v++) if (m_act[v] && m_key[v] == svc_on) dup = 1;
        for (int v = NV - 1; v >= 0; v--) if (!m_act[v]) fv = v;
        if (!dup && fv >= 0) begin
          m_key[fv] = svc_on; m_act[fv] = 1; m_trig[fv] = 1; m_tcyc[fv] = cyc;
        end else if (!dup) begin
          best = 0; best_age = -1;
          for (int v = 0; v < NV; v++) begin
            a = cyc - 1 - m_tcyc[v];
            if (a > 255) a = 255;
            if (a > best_age) begin best = v; best_age = a; end
          end
          m_vic = best; m_skey = svc_on; m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_rel[m_vic] = 1; m_act[m_vic] = 0; m_phase = 2;
    end else begin
      m_key[m_vic] = m_skey; m_act[m_vic] = 1; m_trig[m_vic] = 1; m_tcyc[m_vic] = cyc; m_phase = 0;
    end
    for (int k = 0; k < NK; k++) begin
      if (k == svc_off) m_poff[k] = 0;
      if (k == svc_on)  m_pon[k]  = 0;
      if (kl[k] && !m_kq[k]) m_pon[k] = 1;
      if (!kl[k] && m_kq[k]) begin
        if (m_pon[k]) m_pon[k] = 0;
        else          m_poff[k] = 1;
      end
      m_kq[k] = kl[k];
    end
  endtask

  task automatic tick();
    model_step(key_level, rst_n);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_level = '0;
    tick(); tick();
    n_checks++;
    if (voice_active !== '0 || voice_trig !== '0 || voice_rel !== '0 || busy !== 1'b0 || voice_key !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got act=%b trig=%b rel=%b busy=%b key=%h, required all 0",
               voice_active, voice_trig, voice_rel, busy, voice_key);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_key();
    key_level = 8'h04;
    tick();
    n_checks++;
    if (voice_trig !== 4'b0000) begin n_fail++; $display("FAIL single_early_trig: got %b required 0000", voice_trig); end
    tick();
    n_checks++;
    if (voice_trig !== 4'b0001 || voice_active !== 4'b0001 || voice_key[2:0] !== 3'd2) begin
      n_fail++;
      $display("FAIL single_trig: got trig=%b act=%b key0=%0d required 0001/0001/2", voice_trig, voice_active, voice_key[2:0]);
    end
    tick();
    n_checks++;
    if (voice_trig !== 4'b0000) begin n_fail++; $display("FAIL single_trig_width: got %b required 0000", voice_trig); end
    key_level = 8'h00;
    tick(); tick();
    n_checks++;
    if (voice_rel !== 4'b0001 || voice_active !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_rel: got rel=%b act=%b required 0001/0000", voice_rel, voice_active);
    end
    tick();
    n_checks++;
    if (voice_rel !== 4'b0000) begin n_fail++; $display("FAIL single_rel_width: got %b required 0000", voice_rel); end
  endtask

  task automatic test_simultaneous();
    key_level = 8'h0F;
    tick();
    for (int i = 0; i < NV; i++) begin
      tick();
      n_checks++;
      if (voice_trig !== 4'(1 << i) || voice_key[i*KW +: KW] !== 3'(i) || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL simul_trig%0d: got trig=%b key=%0d busy=%b required %b/%0d/0",
                 i, voice_trig, voice_key[i*KW +: KW], busy, 4'(1 << i), i);
      end
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_steal();
    key_level = 8'h2F;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b1 || voice_trig !== 4'b0000 || voice_rel !== 4'b0000) begin
      n_fail++;
      $display("FAIL steal_decide: got busy=%b trig=%b rel=%b required 1/0000/0000", busy, voice_trig, voice_rel);
    end
    tick();
    n_checks++;
    if (voice_rel !== 4'b0001 || voice_trig !== 4'b0000 || voice_active !== 4'b1110 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL steal_rel: got rel=%b trig=%b act=%b busy=%b required 0001/0000/1110/1",
               voice_rel, voice_trig, voice_active, busy);
    end
    tick();
    n_checks++;
    if (voice_trig !== 4'b0001 || voice_rel !== 4'b0000 || voice_key[2:0] !== 3'd5 || voice_active !== 4'b1111 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL steal_trig: got trig=%b rel=%b key0=%0d act=%b busy=%b required 0001/0000/5/1111/0",
               voice_trig, voice_rel, voice_key[2:0], voice_active, busy);
    end
    tick();
  endtask

  task automatic test_precedence();
    key_level = 8'h6D;
    tick(); tick();
    n_checks++;
    if (voice_rel !== 4'b0010 || voice_trig !== 4'b0000 || voice_active !== 4'b1101 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prec_off_first: got rel=%b trig=%b act=%b busy=%b required 0010/0000/1101/0",
               voice_rel, voice_trig, voice_active, busy);
    end
    tick();
    n_checks++;
    if (voice_trig !== 4'b0010 || voice_key[5:3] !== 3'd6 || voice_active !== 4'b1111 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prec_on_reuse: got trig=%b key1=%0d act=%b busy=%b required 0010/6/1111/0",
               voice_trig, voice_key[5:3], voice_active, busy);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_glitch();
    int stray;
    key_level = 8'h7D;
    tick(); tick();
    key_level = 8'hFD;
    tick();
    n_checks++;
    if (voice_rel !== 4'b0100) begin n_fail++; $display("FAIL glitch_victim_rel: got %b required 0100", voice_rel); end
    key_level = 8'h7D;
    tick();
    n_checks++;
    if (voice_trig !== 4'b0100 || voice_key[8:6] !== 3'd4) begin
      n_fail++;
      $display("FAIL glitch_victim_trig: got trig=%b key2=%0d required 0100/4", voice_trig, voice_key[8:6]);
    end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (voice_trig !== 4'b0000 || voice_rel !== 4'b0000 || busy !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL glitch_no_pulse: got %0d cycles with pulses/busy required 0", stray); end
  endtask

  task automatic test_reset_mid_steal();
    key_level = 8'h7F;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_steal_enter: got busy=%b required 1", busy); end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (voice_active !== '0 || voice_trig !== '0 || voice_rel !== '0 || busy !== 1'b0 || voice_key !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_steal: got act=%b trig=%b rel=%b busy=%b key=%h required all 0",
               voice_active, voice_trig, voice_rel, busy, voice_key);
    end
    rst_n = 1'b1; key_level = '0;
    tick(); tick();
    n_checks++;
    if (voice_trig !== '0 || voice_rel !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_quiet_after: got trig=%b rel=%b busy=%b required 0/0/0", voice_trig, voice_rel, busy);
    end
  endtask

  task automatic test_age_saturation();
    key_level = 8'h0F;
    for (int i = 0; i < 8; i++) tick();
    key_level = 8'h0E;
    for (int i = 0; i < 4; i++) tick();
    key_level = 8'h0F;
    for (int i = 0; i < 300; i++) tick();
    key_level = 8'h1F;
    tick(); tick(); tick();
    n_checks++;
    if (voice_rel !== 4'b0001) begin n_fail++; $display("FAIL sat_tie_victim: got rel=%b required 0001", voice_rel); end
    tick();
    n_checks++;
    if (voice_trig !== 4'b0001 || voice_key[2:0] !== 3'd4) begin
      n_fail++;
      $display("FAIL sat_tie_trig: got trig=%b key0=%0d required 0001/4", voice_trig, voice_key[2:0]);
    end
  endtask

  task automatic test_random();
    logic [NV-1:0]    e_act, e_trig, e_rel;
    logic [NV*KW-1:0] e_key;
    rst_n = 1'b0; key_level = '0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3, 0) == 0) key_level[$urandom_range(NK - 1, 0)] ^= 1'b1;
      rst_n = ($urandom_range(599, 0) != 0);
      tick();
      for (int v = 0; v < NV; v++) begin
        e_act[v] = m_act[v]; e_trig[v] = m_trig[v]; e_rel[v] = m_rel[v];
        e_key[v*KW +: KW] = KW'(m_key[v]);
      end
      n_checks++;
      if (voice_active !== e_act) begin n_fail++; $display("FAIL rand_active c=%0d: got %b required %b", c, voice_active, e_act); end
      n_checks++;
      if (voice_key !== e_key) begin n_fail++; $display("FAIL rand_key c=%0d: got %h required %h", c, voice_key, e_key); end
      n_checks++;
      if (voice_trig !== e_trig) begin n_fail++; $display("FAIL rand_trig c=%0d: got %b required %b", c, voice_trig, e_trig); end
      n_checks++;
      if (voice_rel !== e_rel) begin n_fail++; $display("FAIL rand_rel c=%0d: got %b required %b", c, voice_rel, e_rel); end
      n_checks++;
      if (busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rand_busy c=%0d: got %b required %b", c, busy, m_phase != 0); end
    end
  endtask

  initial begin
    cyc = 0; m_phase = 0; m_vic = 0; m_skey = 0;
    test_reset();
    test_single_key();
    test_simultaneous();
    test_steal();
    test_precedence();
    test_glitch();
    test_reset_mid_steal();
    test_age_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony scheduler for the synthesizer.
- Inputs are NUM_KEYS debounced key levels, one per switch-debouncer output.
- Shares NUM_VOICES tone-generator voices among the keys: a pressed key gets a voice, a released key frees it, and when every voice is busy the oldest voice is stolen.
- Outputs drive each voice: active flag, assigned key index, and one-cycle trigger and release pulses for the envelope.

Parameters:
- NUM_KEYS, 8: number of debounced key inputs.
- NUM_VOICES, 4: number of tone-generator voices.
- KEY_W, 3: key index width, equal to clog2(NUM_KEYS).
- AGE_W, 8: width of each voice's saturating age counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- key_level  in  NUM_KEYS  debounced key levels; 1 = pressed.
- voice_active  out  NUM_VOICES  voice v is sounding.
- voice_key  out  NUM_VOICES*KEY_W  key index held by voice v, in slice [v*KEY_W +: KEY_W].
- voice_trig  out  NUM_VOICES  1-cycle pulse: voice v starts its note.
- voice_rel  out  NUM_VOICES  1-cycle pulse: voice v releases its note.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, key_q=0, pending_on=pending_off=0, ages=0, state=IDLE.
- Edge detect: key_q registers key_level every cycle.
  - rise = key_level & ~key_q; fall = ~key_level & key_q.
  - A rise sets pending_on[k]; a fall sets pending_off[k].
  - A fall while pending_on[k] is set clears pending_on[k] and does not set pending_off[k]. A press the allocator never saw produces no release.
- Event select, in IDLE only:
  - Any pending_off takes precedence over pending_on.
  - Within each class, the lowest key index wins.
  - A pending bit clears in the cycle its event is serviced. A new edge on the same key in that same cycle wins and re-sets the bit.
- IDLE, off event for key k:
  - If an active voice v holds k: voice_active[v]<=0 and voice_rel[v] pulses.
  - If no voice holds k (it was stolen): discard the event silently.
  - Stay in IDLE.
- IDLE, on event for key k:
  - If k already sits on an active voice: discard; duplicates are not allowed.
  - Else if any voice is free: take the lowest-index free v. Set voice_key[v]<=k, voice_active[v]<=1, pulse voice_trig[v], reset age[v]<=0. Stay in IDLE.
  - Else: victim = voice with the largest age, lowest index on a tie. Latch victim and k, then go to STEAL_REL.
- STEAL_REL (1 cycle): voice_rel[victim] pulses and voice_active[victim]<=0. Go to STEAL_TRIG.
- STEAL_TRIG (1 cycle): voice_key[victim]<=k, voice_active<=1, voice_trig pulses, age<=0. Go to IDLE.
- Stealing therefore never produces rel and trig on the same voice in the same cycle.
- Edges arriving during STEAL_* are still captured into the pending vectors and serviced after the return to IDLE.
- Ages: every cycle, each active voice not being (re)triggered increments its age, saturating at 2^AGE_W-1. Inactive voices hold 0.
- Latency:
  - key_level change sampled at edge N sets pending at edge N+1.
  - With no competing events, service happens at edge N+2, so outputs and pulses are visible after edge N+2.
  - A steal adds 1 cycle for trig.
- At most one voice changes state per cycle. Pulses are never asserted outside their defined cycle.
- Reset mid-steal: return to IDLE, all voices inactive, no pulses.

Decomposition:
- Shared package synth_pkg holds:
  - state encoding IDLE/STEAL_REL/STEAL_TRIG (2 bits);
  - default NUM_KEYS, NUM_VOICES, AGE_W;
  - the clog2 helper.
- One sub-module, voice_age_tracker. It holds the per-voice saturating age counters and outputs the oldest-voice index, lowest index on a tie. Its inputs are voice_active and a per-voice clear vector.
- Edge detect, pending vectors, the FSM and the voice registers live in voice_allocator.

Test Plan:
- Single key: reset, then key_level=8'h04 -> 2 cycles later voice_trig=4'b0001, voice_key[0]=2, voice_active=4'b0001. key_level=0 -> 2 cycles later voice_rel=4'b0001, voice_active=0.
- Simultaneous presses: key_level 0 -> 8'h0F in one cycle -> trigs on voices 0,1,2,3 on four consecutive cycles, holding keys 0,1,2,3.
- Steal: keys 0..3 held and aged, then key 5 pressed -> voice 0 (oldest) gets rel, next cycle trig with voice_key[0]=5. busy=1 for exactly 2 cycles.
- Precedence: key 1 released and key 6 pressed in the same cycle with all voices busy -> off serviced first, freed voice 1 takes key 6, no steal.
- Glitch: key 7 pressed then released before service while busy in a steal -> no trig or rel for key 7.
- Reset in STEAL_REL: rst_n=0 for one cycle -> all outputs 0 next cycle, busy=0.
